// File: rtl/relu_pool2x2_if.sv
// rtl/relu_pool2x2_if.sv - handshake bundle between relu_pool2x2 and its producer/consumer
interface relu_pool2x2_if #(
  parameter int DW = 32
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_addr;
  logic          done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr, done
  );
endinterface

// File: rtl/relu_pool2x2.sv
// rtl/relu_pool2x2.sv - streaming ReLU followed by 2x2 max-pool over a raster-order feature map
module relu_pool2x2 #(
  parameter int DW   = 32,
  parameter int COLS = 10,
  parameter int ROWS = 10
) (
  input  logic          clk,
  input  logic          rst,
  relu_pool2x2_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam int HC  = COLS / 2;
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int LBW = (HC > 1) ? $clog2(HC) : 1;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] h;
  logic [DW-1:0] out_data_q;
  logic [7:0]    out_addr_q;
  logic          out_valid_q;
  logic          done_q;
  logic [DW-1:0] linebuf [HC];

  logic          in_xfer;
  logic          out_xfer;
  logic [DW-1:0] r;
  logic [LBW-1:0] lb_idx;
  logic [DW-1:0] lb_rd;
  logic          col_last;
  logic          row_last;
  logic [7:0]    pool_addr;
  logic          emit;

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Single output register: input may advance whenever that register is free or draining.
  assign bus.in_ready  = (state == S_RUN) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.done      = done_q;

  assign in_xfer   = bus.in_valid && bus.in_ready;
  assign out_xfer  = out_valid_q && bus.out_ready;
  assign r         = bus.in_data[DW-1] ? '0 : bus.in_data;
  assign lb_idx    = LBW'(col >> 1);
  assign lb_rd     = linebuf[lb_idx];
  assign col_last  = (col == CW'(COLS - 1));
  assign row_last  = (row == RW'(ROWS - 1));
  assign pool_addr = 8'(row >> 1) * 8'(HC) + 8'(col >> 1);
  assign emit      = in_xfer && row[0] && col[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      h           <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        S_RUN: begin
          if (in_xfer) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= S_FLUSH;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (out_xfer) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Even columns open a window half: odd rows fold in the stored top-row max.
      if (in_xfer && !col[0]) begin
        h <= row[0] ? umax(lb_rd, r) : r;
      end

      if (emit) begin
        out_data_q  <= umax(h, r);
        out_addr_q  <= pool_addr;
        out_valid_q <= 1'b1;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && !row[0] && col[0]) begin
      linebuf[lb_idx] <= umax(h, r);
    end
  end
endmodule

// File: tb/tb_relu_pool2x2.sv
// tb/tb_relu_pool2x2.sv - scoreboard bench for relu_pool2x2 with directed feature maps
module tb_relu_pool2x2;
  localparam int DW = 32;

  typedef struct {
    logic [7:0]    addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu_pool2x2_if #(.DW(DW)) bus ();

  relu_pool2x2 #(.DW(DW), .COLS(10), .ROWS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   expect_done = 1'b0;
  bit   stall_req   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] val(input int kind, input int r, input int c);
    if (kind == 1) return DW'(-5);
    if (kind == 2 && r == 0 && c == 0) return DW'(-1);
    if (kind == 2 && r == 0 && c == 1) return DW'(7);
    if (kind == 2 && r == 1 && c == 0) return DW'(-3);
    if (kind == 2 && r == 1 && c == 1) return DW'(2);
    return DW'(r * 10 + c);
  endfunction

  function automatic logic [DW-1:0] exp_val(input int kind, input int k);
    if (kind == 1) return '0;
    if (kind == 2 && k == 0) return DW'(7);
    return DW'((2 * (k / 5) + 1) * 10 + 2 * (k % 5) + 1);
  endfunction

  task automatic push_map(input int kind, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = 8'(k);
      e.data = exp_val(kind, k);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic feed(input int kind, input bit gap, input bit stray, input int n);
    for (int i = 0; i < n; i++) begin
      int  rr = i / 10;
      int  cc = i % 10;
      int  t  = 0;
      bit  acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = val(kind, rr, cc);
      if (stray && i == 13) bus.start = 1'b1;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t++;
      end
      if (!acc) chk("in_accept_timeout", 64'(acc), 64'd1);
      bus.in_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(bus.out_data),  64'd0);
    chk({tag, "_out_addr"},  64'(bus.out_addr),  64'd0);
    chk({tag, "_done"},      64'(bus.done),      64'd0);
  endtask

  // Output transfers commit on the next rising edge; everything is stable at the falling edge.
  always @(negedge clk) begin
    if (expect_done) begin
      chk("done_pulse", 64'(bus.done), 64'd1);
      expect_done = 1'b0;
    end else if (bus.done) begin
      chk("done_spurious", 64'(bus.done), 64'd0);
    end
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(bus.out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_addr", 64'(bus.out_addr), 64'(mon_e.addr));
        chk("out_data", 64'(bus.out_data), 64'(mon_e.data));
        if (mon_e.addr == 8'd24) expect_done = 1'b1;
      end
    end
  end

  initial begin
    bit stall_done = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_req && !stall_done && bus.out_valid && bus.out_addr == 8'd3) begin
        stall_done = 1'b1;
        bus.out_ready = 1'b0;
        repeat (6) begin
          @(negedge clk);
          chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
          chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
          chk("stall_out_addr",  64'(bus.out_addr),  64'd3);
          chk("stall_out_data",  64'(bus.out_data),  64'd17);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // plain ramp
    push_map(0, 25);
    pulse_start();
    feed(0, 1'b0, 1'b0, 100);
    drain();

    // all-negative map pools to zero
    push_map(1, 25);
    pulse_start();
    feed(1, 1'b0, 1'b0, 100);
    drain();

    // mixed-sign window at origin
    push_map(2, 25);
    pulse_start();
    feed(2, 1'b0, 1'b0, 100);
    drain();

    // consumer stall on addr 3
    stall_req = 1'b1;
    push_map(0, 25);
    pulse_start();
    feed(0, 1'b0, 1'b0, 100);
    drain();

    // gapped input
    push_map(0, 25);
    pulse_start();
    feed(0, 1'b1, 1'b0, 100);
    drain();

    // reset mid-map after 37 inputs
    push_map(0, 8);
    pulse_start();
    feed(0, 1'b0, 1'b0, 37);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_drained", 64'(sb.size()), 64'd0);
    rst = 1'b0;
    #1;
    chk_reset_state("midmap_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(99);
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    push_map(0, 25);
    pulse_start();
    feed(0, 1'b0, 1'b0, 100);
    drain();

    // stray in_valid while idle, stray start while running
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(500);
    repeat (3) begin
      @(negedge clk);
      chk("idle_stray_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    push_map(0, 25);
    pulse_start();
    feed(0, 1'b0, 1'b1, 100);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/relu_pool2x2.md
RELU_POOL2X2 -- requirements
Module: relu_pool2x2

Interface
REQ-001 Parameter: DW, 32, signed data width of PE output words.
REQ-002 Parameter: COLS, 10, input feature-map columns (even, >=2).
REQ-003 Parameter: ROWS, 10, input feature-map rows (even, >=2).
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  one-cycle pulse, begins one feature map; honoured only in IDLE.
REQ-007 Port: in_valid  input  1  in_data valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: in_data  input  DW  signed PE result, raster order (row-major, col 0..COLS-1).
REQ-010 Port: out_valid  output  1  pooled result held on out_data/out_addr.
REQ-011 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 Port: out_data  output  DW  ReLU'd 2x2 max, non-negative.
REQ-013 Port: out_addr  output  8  pooled index = (row/2)*(COLS/2) + (col/2).
REQ-014 Port: done  output  1  one-cycle pulse after the final pooled word is accepted.

Function
REQ-015 States: IDLE, RUN, FLUSH; transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-016 IDLE: in_ready=0; start -> RUN, row/col counters cleared, line buffer contents don't-care.
REQ-017 RUN: in_ready = !out_valid | out_ready (single-entry output register, one-cycle bubble-free pass-through).
REQ-018 ReLU per input: r = (in_data[DW-1]) ? 0 : in_data; comparisons unsigned on r.
REQ-019 Even row, even col: hold register h <= r.
REQ-020 Even row, odd col: linebuf[col/2] <= max(h, r); linebuf depth COLS/2, width DW.
REQ-021 Odd row, even col: h <= max(linebuf[col/2], r).
REQ-022 Odd row, odd col: out_data <= max(h, r), out_addr <= computed index, out_valid <= 1 on the same edge.
REQ-023 out_valid clears on transfer out unless a new result is loaded on the same edge (then stays 1).
REQ-024 Counters: col increments per transfer in, wraps COLS-1 -> 0 and increments row; row ROWS-1/col COLS-1 transfer -> FLUSH.
REQ-025 FLUSH: in_ready=0; on transfer out of last word -> IDLE with done=1 for exactly that one cycle (registered).
REQ-026 Latency: pooled word visible on out_valid the cycle after its 4th contributing input is accepted.
REQ-027 start during RUN/FLUSH ignored; in_valid in IDLE/FLUSH ignored, no state change.
REQ-028 Equal values: max returns either operand (identical); all-negative window yields 0.
REQ-029 Output stall: out_ready low holds out_data/out_addr/out_valid stable; in_ready low until drained.
REQ-030 Total pooled words per map = (ROWS/2)*(COLS/2) = 25 with defaults; out_addr 0..24 strictly increasing.

Reset
REQ-031 rst low asynchronously forces IDLE, counters 0, h 0, out_valid 0, out_data 0, out_addr 0, done 0, in_ready 0.
REQ-032 Line buffer need not be reset; it is fully written before read in every map.
REQ-033 rst asserted mid-map abandons the map; after release, no output until next start.

Verification
REQ-034 Ramp: start, feed in_data = row*10+col, out_ready=1 -> 25 words, out_addr k holds 22*... i.e. value (2*(k/5)+1)*10+2*(k%5)+1; done one cycle after addr 24.
REQ-035 ReLU: all inputs -5 -> 25 words all 0; window {-1, 7, -3, 2} at map origin -> out_addr 0 = 7.
REQ-036 Backpressure: out_ready=0 for 6 cycles when addr 3 appears -> in_ready=0, out_data/out_addr frozen, no word lost or duplicated.
REQ-037 Gapped input: in_valid toggling 1/0 each cycle -> identical output sequence to REQ-034.
REQ-038 Reset mid-map: rst low after 37 inputs, release, start, full ramp -> exactly 25 correct words from addr 0, no stale output.
REQ-039 Stray controls: start pulses during RUN and in_valid during IDLE -> no counter change, results unchanged.
